// File: rtl/fp8_conv_pkg.sv
// Shared constants and types for the Q6.11 -> E3M4 conversion path.
// Imported by the arbiter and the round-robin sub-module.
package fp8_conv_pkg;

  localparam int Q_W    = 18;
  localparam int Q_FRAC = 11;
  localparam int FP_W   = 8;
  localparam int E_W    = 3;
  localparam int M_W    = 4;
  localparam int E_BIAS = 4;

  localparam logic [6:0] FP_SAT_MAG = 7'h7F;

  typedef struct packed {
    logic           sign;
    logic [E_W-1:0] exp;
    logic [M_W-1:0] mant;
  } fp8_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Index of the highest set bit; 0 when the operand is zero.
  function automatic logic [4:0] msb_idx(input logic [Q_W-1:0] a);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < Q_W; i++) begin
      if (a[i]) p = 5'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/fp8_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// Pointer advances past the winner whenever a grant is issued.
module rr_arbiter
  import fp8_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               gnt_valid
);

  logic [ID_W-1:0] ptr;
  logic            found;

  // Cyclic priority search starting at the pointer
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NUM_REQ]) begin
        found = 1'b1;
        idx   = ID_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
    gnt_valid  = found & en;
    grant[idx] = gnt_valid;
  end

  // Pointer moves one past the winner on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      if (idx == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                           ptr <= idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/fp8_conv_arbiter.sv
// Shared Q6.11 -> E3M4 converter with round-robin input arbitration.
// Optional stats counters enabled by defining CONV_STATS_EN.
module fp8_conv_arbiter
  import fp8_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [Q_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP_W-1:0]        out_fp,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_sat
`ifdef CONV_STATS_EN
  ,
  output logic [15:0]            sat_cnt,
  output logic [15:0]            uflow_cnt
`endif
);

  out_state_t state, state_nxt;

  logic            can_accept;
  logic            arb_en;
  logic            xfer;
  logic [ID_W-1:0] gnt_idx;
  logic [Q_W-1:0]  lane [NUM_REQ];

  logic           sgn;
  logic [Q_W-1:0] q;
  logic [Q_W-1:0] mag;
  logic [Q_W-1:0] norm;
  logic [4:0]     p;
  logic [4:0]     mr;
  logic [5:0]     ex;
  fp8_t           conv_fp;
  logic           conv_sat;
  logic           conv_uf;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign lane[k] = req_data[Q_W*k +: Q_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (req_ready),
    .idx       (gnt_idx),
    .gnt_valid (xfer)
  );

  // Output-stage state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next state: fill on transfer, drain when downstream takes the result
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs; no grants while reset is held
  always_comb begin
    out_valid  = (state == FULL);
    can_accept = (state == EMPTY) | out_ready;
    arb_en     = can_accept & ~rst;
  end

  // Conversion of the granted operand to E3M4
  always_comb begin
    q        = lane[gnt_idx];
    sgn      = q[Q_W-1];
    mag      = sgn ? (~q + Q_W'(1)) : q;
    p        = msb_idx(mag);
    norm     = mag << (5'd17 - p);
    mr       = {1'b0, norm[16:13]} + {4'b0, norm[12]};
    ex       = {1'b0, p} - 6'd7 + {5'b0, mr[4]};
    conv_fp  = '0;
    conv_sat = 1'b0;
    conv_uf  = 1'b0;
    if (mag == '0) begin
      conv_fp = '0;
    end else if (p < 5'd8) begin
      conv_uf = 1'b1;
    end else if (ex > 6'd7) begin
      conv_fp  = {sgn, FP_SAT_MAG};
      conv_sat = 1'b1;
    end else begin
      conv_fp = {sgn, ex[2:0], mr[3:0]};
    end
  end

  // Result register loads on every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      out_fp  <= '0;
      out_id  <= '0;
      out_sat <= 1'b0;
    end else if (xfer) begin
      out_fp  <= conv_fp;
      out_id  <= gnt_idx;
      out_sat <= conv_sat;
    end
  end

`ifdef CONV_STATS_EN
  // Saturating counts of overflowed and flushed conversions
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt   <= '0;
      uflow_cnt <= '0;
    end else if (xfer) begin
      if (conv_sat && sat_cnt != 16'hFFFF)  sat_cnt   <= sat_cnt + 16'd1;
      if (conv_uf && uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 16'd1;
    end
  end
`endif

endmodule
